// File: rtl/axis_fifo_scheduler_pkg.sv
// Shared types and constants for the round-robin AXI-Stream burst scheduler.
package axis_fifo_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int DEFAULT_CHANNELS = 4;
  localparam int ID_WIDTH         = $clog2(DEFAULT_CHANNELS);

endpackage

// File: rtl/axis_fifo_scheduler_if.sv
// Bundles the per-channel input streams and the merged output stream.
interface axis_fifo_scheduler_if
  import axis_fifo_scheduler_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CHANNELS         = DEFAULT_CHANNELS,
  parameter int ID_W             = ID_WIDTH
);

  logic [CHANNELS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
  logic [CHANNELS-1:0]                  s_axis_tvalid;
  logic [CHANNELS-1:0]                  s_axis_tready;

  logic [AXIS_TDATA_WIDTH-1:0]          m_axis_tdata;
  logic                                 m_axis_tvalid;
  logic                                 m_axis_tready;
  logic                                 m_axis_tlast;
  logic [ID_W-1:0]                      m_axis_tuser;

  // Scheduler side: consumes the FIFO streams, produces the merged stream.
  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast,
    output m_axis_tuser
  );

  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast,
    input  m_axis_tuser
  );

endinterface

// File: rtl/axis_fifo_scheduler_rr_picker.sv
// Combinational round-robin priority encoder: first requester above last_i, wrapping.
module rr_picker #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_i,
  output logic           any_o,
  output logic [IDW-1:0] idx_o
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int k = N; k >= 1; k--) begin
      cand = (int'(last_i) + k) % N;
      if (req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_fifo_scheduler.sv
// Drains per-source FIFOs into one AXI-Stream in fixed-length bursts, round-robin
// across channels whose occupancy has reached the configured burst length.
module axis_fifo_scheduler
  import axis_fifo_scheduler_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CHANNELS         = 4,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [CNTR_WIDTH-1:0]          cfg_data,
  input  logic [CHANNELS*CNTR_WIDTH-1:0] read_count,
  output logic [31:0]                    sts_data,
  axis_fifo_scheduler_if.master          axis
);

  localparam int ID_W = $clog2(CHANNELS);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0] len_q, len_d;
  logic [31:0]           sts_q, sts_d;

  logic [CHANNELS-1:0]   eligible;
  logic                  any_elig;
  logic [ID_W-1:0]       pick;
  logic                  hs;
  logic                  last_word;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_elig
      assign eligible[gi] = (cfg_data != '0) &&
                            (read_count[gi*CNTR_WIDTH +: CNTR_WIDTH] >= cfg_data);
    end
  endgenerate

  rr_picker #(
    .N   (CHANNELS),
    .IDW (ID_W)
  ) u_rr_picker (
    .req_i  (eligible),
    .last_i (last_q),
    .any_o  (any_elig),
    .idx_o  (pick)
  );

  assign hs        = (state_q == XFER) && axis.s_axis_tvalid[grant_q] && axis.m_axis_tready;
  assign last_word = (cnt_q == len_q - CNTR_WIDTH'(1));
  assign sts_data  = sts_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Last-grant resets to the top channel so channel 0 is first in line.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      grant_q <= '0;
      last_q  <= ID_W'(CHANNELS - 1);
      cnt_q   <= '0;
      len_q   <= '0;
      sts_q   <= '0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sts_q   <= sts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (any_elig) state_d = XFER;
      XFER: if (hs && last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst length is captured at grant time so cfg_data may change mid-burst.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sts_d   = sts_q;
    if (state_q == IDLE) begin
      if (any_elig) begin
        grant_d = pick;
        len_d   = cfg_data;
        cnt_d   = '0;
      end
    end else if (hs) begin
      cnt_d = cnt_q + CNTR_WIDTH'(1);
      if (last_word) begin
        last_d = grant_q;
        sts_d  = sts_q + 32'd1;
      end
    end
  end

  always_comb begin
    axis.s_axis_tready = '0;
    axis.m_axis_tdata  = '0;
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tlast  = 1'b0;
    axis.m_axis_tuser  = '0;
    if (state_q == XFER) begin
      axis.m_axis_tdata           = axis.s_axis_tdata[grant_q*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
      axis.m_axis_tvalid          = axis.s_axis_tvalid[grant_q];
      axis.m_axis_tlast           = last_word;
      axis.m_axis_tuser           = grant_q;
      axis.s_axis_tready[grant_q] = axis.m_axis_tready;
    end
  end

endmodule

// File: tb/tb_axis_fifo_scheduler.sv
// Directed bench for axis_fifo_scheduler: FWFT FIFO sources, hand-computed bursts.
module tb_axis_fifo_scheduler;

  localparam int DW = 32;
  localparam int CH = 4;
  localparam int CW = 16;

  logic           aclk;
  logic           aresetn;
  logic [CW-1:0]  cfg_data;
  logic [CH*CW-1:0] read_count;
  logic [31:0]    sts_data;

  int checks   = 0;
  int failures = 0;
  int ptr[CH];
  int exp_ptr[CH];

  axis_fifo_scheduler_if #(.AXIS_TDATA_WIDTH(DW), .CHANNELS(CH), .ID_W(2)) ifc ();

  axis_fifo_scheduler #(
    .AXIS_TDATA_WIDTH (DW),
    .CHANNELS         (CH),
    .CNTR_WIDTH       (CW)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cfg_data   (cfg_data),
    .read_count (read_count),
    .sts_data   (sts_data),
    .axis       (ifc)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] word(int ch, int idx);
    return 32'hA000_0000 + (32'(ch) << 16) + 32'(idx);
  endfunction

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s val=%0h t=%0t", tag, got, $time);
    end
  endtask

  task automatic drive_data();
    for (int ch = 0; ch < CH; ch++) ifc.s_axis_tdata[ch*DW +: DW] = word(ch, ptr[ch]);
  endtask

  // FIFO model pops whatever was accepted at the edge.
  task automatic tick();
    logic [CH-1:0] fire;
    fire = ifc.s_axis_tready & ifc.s_axis_tvalid;
    @(posedge aclk);
    #1;
    for (int ch = 0; ch < CH; ch++) if (fire[ch]) ptr[ch]++;
    drive_data();
  endtask

  task automatic set_rc(int a, int b, int c, int d);
    read_count = {CW'(d), CW'(c), CW'(b), CW'(a)};
  endtask

  task automatic expect_idle(string tag);
    #1;
    check_val({tag, "_idle_tvalid"}, 64'(ifc.m_axis_tvalid), 64'd0);
    check_val({tag, "_idle_tready"}, 64'(ifc.s_axis_tready), 64'd0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    #1;
    check_val("rst_tready", 64'(ifc.s_axis_tready), 64'd0);
    check_val("rst_tvalid", 64'(ifc.m_axis_tvalid), 64'd0);
    check_val("rst_tlast",  64'(ifc.m_axis_tlast),  64'd0);
    check_val("rst_sts",    64'(sts_data),          64'd0);
    aresetn = 1'b1;
  endtask

  task automatic run_burst(string tag, int ch, int len);
    for (int k = 0; k < len; k++) begin
      #1;
      check_val({tag, "_tvalid"}, 64'(ifc.m_axis_tvalid), 64'd1);
      check_val({tag, "_tuser"},  64'(ifc.m_axis_tuser),  64'(ch));
      check_val({tag, "_tdata"},  64'(ifc.m_axis_tdata),  64'(word(ch, exp_ptr[ch] + k)));
      check_val({tag, "_tlast"},  64'(ifc.m_axis_tlast),  64'(k == len - 1));
      tick();
    end
    exp_ptr[ch] += len;
  endtask

  int order[5] = '{0, 1, 2, 3, 0};
  logic mr_tab[5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int   k_tab[5]    = '{0, 1, 1, 2, 2};
  logic last_tab[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    for (int ch = 0; ch < CH; ch++) begin
      ptr[ch] = 0;
      exp_ptr[ch] = 0;
    end
    aresetn = 1'b0;
    cfg_data = '0;
    read_count = '0;
    ifc.s_axis_tvalid = '1;
    ifc.m_axis_tready = 1'b1;
    drive_data();

    // Single eligible channel, one 4-word burst.
    do_reset();
    cfg_data = 16'd4;
    set_rc(8, 0, 0, 0);
    expect_idle("s1");
    tick();
    run_burst("s1", 0, 4);
    set_rc(0, 0, 0, 0);
    expect_idle("s1_end");
    check_val("s1_sts", 64'(sts_data), 64'd1);

    // All eligible: round-robin 0,1,2,3,0 with a bubble between bursts.
    do_reset();
    cfg_data = 16'd2;
    set_rc(5, 5, 5, 5);
    for (int b = 0; b < 5; b++) begin
      expect_idle("s2");
      tick();
      run_burst("s2", order[b], 2);
    end
    set_rc(0, 0, 0, 0);
    expect_idle("s2_end");
    check_val("s2_sts", 64'(sts_data), 64'd5);

    // Backpressure toggling on a 3-word burst from channel 2.
    cfg_data = 16'd3;
    set_rc(0, 0, 3, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      ifc.m_axis_tready = mr_tab[c];
      #1;
      check_val("s3_tvalid", 64'(ifc.m_axis_tvalid), 64'd1);
      check_val("s3_tuser",  64'(ifc.m_axis_tuser),  64'd2);
      check_val("s3_tdata",  64'(ifc.m_axis_tdata),  64'(word(2, exp_ptr[2] + k_tab[c])));
      check_val("s3_tlast",  64'(ifc.m_axis_tlast),  64'(last_tab[c]));
      check_val("s3_tready", 64'(ifc.s_axis_tready), 64'(mr_tab[c]) << 2);
      tick();
    end
    exp_ptr[2] += 3;
    ifc.m_axis_tready = 1'b1;
    set_rc(0, 0, 0, 0);
    expect_idle("s3_end");
    check_val("s3_sts", 64'(sts_data), 64'd6);

    // Burst length latched: cfg drops to 1 mid-burst, takes effect next burst.
    cfg_data = 16'd4;
    set_rc(0, 8, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) cfg_data = 16'd1;
      #1;
      check_val("s4_tuser", 64'(ifc.m_axis_tuser), 64'd1);
      check_val("s4_tdata", 64'(ifc.m_axis_tdata), 64'(word(1, exp_ptr[1] + k)));
      check_val("s4_tlast", 64'(ifc.m_axis_tlast), 64'(k == 3));
      tick();
    end
    exp_ptr[1] += 4;
    expect_idle("s4_mid");
    tick();
    run_burst("s4b", 1, 1);
    set_rc(0, 0, 0, 0);
    expect_idle("s4_end");
    check_val("s4_sts", 64'(sts_data), 64'd8);

    // cfg_data = 0 disables scheduling entirely.
    do_reset();
    cfg_data = 16'd0;
    set_rc(100, 100, 100, 100);
    for (int c = 0; c < 6; c++) begin
      expect_idle("s5");
      tick();
    end
    check_val("s5_sts", 64'(sts_data), 64'd0);

    // Reset after 2 of 4 words abandons the burst; channel 0 is first afterwards.
    cfg_data = 16'd4;
    set_rc(0, 0, 8, 0);
    expect_idle("s6");
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      check_val("s6_tdata", 64'(ifc.m_axis_tdata), 64'(word(2, exp_ptr[2] + k)));
      tick();
    end
    exp_ptr[2] += 3;
    aresetn = 1'b0;
    tick();
    #1;
    check_val("s6_rst_tready", 64'(ifc.s_axis_tready), 64'd0);
    check_val("s6_rst_tvalid", 64'(ifc.m_axis_tvalid), 64'd0);
    check_val("s6_rst_tlast",  64'(ifc.m_axis_tlast),  64'd0);
    check_val("s6_rst_sts",    64'(sts_data),          64'd0);
    aresetn = 1'b1;
    set_rc(8, 8, 8, 8);
    expect_idle("s6_post");
    tick();
    run_burst("s6_post", 0, 4);
    set_rc(0, 0, 0, 0);
    expect_idle("s6_end");
    check_val("s6_sts", 64'(sts_data), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_fifo_scheduler.md
Name: axis_fifo_scheduler

Overview:
- Round-robin burst scheduler that drains CHANNELS upstream FWFT AXI-Stream FIFOs into one AXI-Stream master.
- A channel becomes eligible when its FIFO read_count reaches the configured burst length.
- The granted channel forwards exactly that many words, tagged with channel id on tuser and tlast on the final word.
- Sits between a bank of per-source FIFOs and a single DMA/writer stream.

Parameters:
AXIS_TDATA_WIDTH, 32, width of each input word and of the output word
CHANNELS, 4, number of upstream FIFOs (2..16)
CNTR_WIDTH, 16, width of burst length and read_count fields

Ports:
aclk  input  1  clock
aresetn  input  1  reset; synchronous, active-low
cfg_data  input  CNTR_WIDTH  burst length in words; 0 disables scheduling
read_count  input  CHANNELS*CNTR_WIDTH  packed per-channel FIFO occupancy, channel i at [i*CNTR_WIDTH +: CNTR_WIDTH]
s_axis_tdata  input  CHANNELS*AXIS_TDATA_WIDTH  packed per-channel data
s_axis_tvalid  input  CHANNELS  per-channel valid
s_axis_tready  output  CHANNELS  per-channel ready
m_axis_tdata  output  AXIS_TDATA_WIDTH  output data
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  output ready
m_axis_tlast  output  1  final word of burst
m_axis_tuser  output  $clog2(CHANNELS)  granted channel id
sts_data  output  32  completed burst count, wraps modulo 2^32

Behaviour:
- Reset (aresetn low at rising edge):
  - state IDLE, grant = 0, last-grant pointer = CHANNELS-1 (channel 0 has first priority), word counter = 0, sts_data = 0.
  - All outputs low: s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0.
- States: IDLE and XFER.
- IDLE:
  - Eligibility: eligible[i] = (cfg_data != 0) && (read_count_i >= cfg_data), unsigned compare.
  - Round-robin pick: first eligible channel searching from last-grant+1 upward, wrapping at CHANNELS-1.
  - If any channel is eligible: register grant, register burst length = cfg_data, clear counter, go to XFER next cycle. Otherwise stay in IDLE.
  - All s_axis_tready = 0; m_axis_tvalid = 0.
- XFER:
  - m_axis_tdata = s_axis_tdata[grant]; m_axis_tvalid = s_axis_tvalid[grant]; m_axis_tuser = grant.
  - s_axis_tready[grant] = m_axis_tready; all other readies = 0.
  - Handshake = s_axis_tvalid[grant] && m_axis_tready; counter increments on each handshake.
  - m_axis_tlast = (counter == burst_len-1), combinational.
  - On the handshake with tlast: last-grant <= grant, sts_data += 1, go to IDLE.
- Latency:
  - Eligibility seen in IDLE at cycle t -> first word offered at t+1.
  - One idle bubble cycle between consecutive bursts (IDLE re-arbitrates).
- cfg_data changes during XFER are ignored (burst length is latched). A change takes effect at the next IDLE evaluation.
- Valid gaps from the granted FIFO stall the burst; there is no timeout and no preemption.
- Backpressure: m_axis_tready low holds the current word, tlast and the counter stable.
- Only one channel eligible: it is granted repeatedly, one burst per IDLE visit.
- read_count rising mid-burst on other channels has no effect until IDLE.
- A channel whose read_count is below burst length is never granted, even if its tvalid is high.
- Reset asserted mid-burst: immediate return to reset state; the partial burst is abandoned (no tlast emitted).

Decomposition:
- Package axis_fifo_scheduler_pkg: state enum {IDLE, XFER}; localparam ID_WIDTH = $clog2(CHANNELS).
- Sub-module rr_picker: combinational round-robin priority encoder.
  - Inputs: request vector, last-grant pointer.
  - Outputs: any-request flag, selected index.
- The top level holds the FSM, counter, muxes and status counter.

Test Plan:
- cfg_data=4, read_count0=8, others 0, all tvalid high, tready high -> IDLE cycle, then 4 words from ch0 with tuser=0, tlast on 4th, sts_data=1.
- cfg_data=2, all channels read_count=5 -> bursts granted in order 0,1,2,3,0, each 2 words, one bubble cycle between bursts.
- cfg_data=3, m_axis_tready toggling 1,0,1,0 -> every word delivered once, tlast only on the 3rd handshake, data stable during stalls.
- cfg_data=4 latched, changed to 1 after word 1 -> current burst still 4 words; next burst 1 word.
- cfg_data=0 with read_count=100 on all channels -> tvalid stays 0, sts_data stays 0.
- Reset pulsed after 2 of 4 words -> all readies 0 next cycle, sts_data=0, next grant goes to channel 0.
